bram_stream_reader: RTL and testbench
=====================================

BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 Parameter RAM_WIDTH, default 16: RAM word width and stream data width.
REQ-002 Parameter RAM_DEPTH, default 4096: RAM entries; ADDR_W = clog2(RAM_DEPTH).
REQ-003 Parameter READ_LATENCY, default 2: cycles from en_out to valid din_in; legal values are 1 and 2.
REQ-004 clk_in  input  1  sole clock, rising edge.
REQ-005 rst_in  input  1  reset; synchronous, active-high.
REQ-006 start_in  input  1  single-cycle pulse that launches a burst.
REQ-007 base_addr_in  input  ADDR_W  first RAM address, sampled on accepted start.
REQ-008 length_in  input  ADDR_W+1  words to read (0..RAM_DEPTH), sampled on accepted start.
REQ-009 addr_out  output  ADDR_W  RAM port address.
REQ-010 en_out  output  1  RAM port enable; one read is issued per high cycle.
REQ-011 regce_out  output  1  RAM output-register enable.
REQ-012 din_in  input  RAM_WIDTH  RAM port read data.
REQ-013 data_out  output  RAM_WIDTH  stream data.
REQ-014 valid_out  output  1  stream valid.
REQ-015 ready_in  input  1  stream ready; a transfer occurs when valid_out and ready_in are both high.
REQ-016 last_out  output  1  marks the final word of a burst.
REQ-017 busy_out  output  1  high from accepted start until the final transfer.
REQ-018 done_out  output  1  single-cycle pulse one cycle after the final transfer.

Function
REQ-019 The state machine SHALL have states IDLE, ISSUE and DRAIN.
REQ-020 Transition IDLE->ISSUE SHALL occur on start_in with length_in != 0.
REQ-021 Transition ISSUE->DRAIN SHALL occur when the last read is issued.
REQ-022 Transition DRAIN->IDLE SHALL occur on the final stream transfer.
REQ-023 A start_in with length_in == 0 SHALL produce no stream output, keep busy_out low, and pulse done_out on the next cycle.
REQ-024 A start_in while busy_out is high SHALL be ignored, with no effect on the current burst.
REQ-025 In ISSUE, en_out SHALL be high only when (reads in flight + FIFO occupancy) < FIFO_DEPTH; credit-based, so no read data is ever dropped.
REQ-026 addr_out SHALL start at base_addr_in and increment by one per issued read.
REQ-027 addr_out SHALL wrap from RAM_DEPTH-1 to 0.
REQ-028 regce_out SHALL equal en_out delayed by one cycle when READ_LATENCY=2, and SHALL be 1 when READ_LATENCY=1.
REQ-029 A READ_LATENCY-deep valid-tag shift register SHALL track in-flight reads.
REQ-030 Each tagged din_in SHALL be written into the skid FIFO on the cycle its tag emerges.
REQ-031 data_out and valid_out SHALL present the FIFO head; valid_out high means the FIFO is non-empty.
REQ-032 data_out SHALL be held stable while valid_out is high and ready_in is low.
REQ-033 A simultaneous FIFO write and read SHALL leave the occupancy unchanged.
REQ-034 The minimum latency from start_in to the first valid_out SHALL be READ_LATENCY+2 cycles.
REQ-035 With ready_in held high, sustained throughput SHALL be one word per cycle.
REQ-036 last_out SHALL be high only with the valid_out of the length_in-th word.
REQ-037 Words SHALL be output in address order with none duplicated or dropped.

Reset
REQ-038 rst_in SHALL force state IDLE and clear the tags, FIFO, address and counters.
REQ-039 During and after reset, valid_out, en_out, regce_out, busy_out, done_out and last_out SHALL be 0, and addr_out and data_out SHALL be 0.
REQ-040 rst_in mid-burst SHALL abandon the burst without a done_out pulse.
REQ-041 RAM reads still in flight when rst_in asserts SHALL be discarded.

Configuration
REQ-042 With macro BRAM_READER_LOOP_EN defined, an extra input loop_in (1 bit) SHALL exist.
REQ-043 With BRAM_READER_LOOP_EN defined and loop_in high at the final issue, the reader SHALL restart issuing at base_addr_in with no idle cycle.
REQ-044 In loop mode, last_out SHALL still mark each burst end, done_out SHALL NOT pulse, and busy_out SHALL remain high.
REQ-045 Clearing loop_in SHALL end the burst currently in progress normally.
REQ-046 Without BRAM_READER_LOOP_EN, the loop_in port and loop logic SHALL be absent and behaviour SHALL be as above.

Structure
REQ-047 Package bram_reader_pkg SHALL hold the state enum and the constant FIFO_DEPTH = 4; FIFO_DEPTH SHALL be at least READ_LATENCY+2.
REQ-048 One sub-module, bram_reader_skid_fifo, SHALL implement the FIFO (parameter RAM_WIDTH and FIFO_DEPTH, with push/pop/full/empty/count).

Verification
REQ-049 Scenario: base=10, len=5, ready_in=1 -> addresses 10..14 issued on consecutive cycles; 5 words in order; last_out on the 5th; done_out once.
REQ-050 Scenario: base=4094, len=4, depth 4096 -> addresses 4094, 4095, 0, 1.
REQ-051 Scenario: len=8 with ready_in toggling 1,0,0,1 repeatedly -> all 8 words exact; en_out never high while credits are exhausted.
REQ-052 Scenario: len=0 -> no valid_out; done_out pulse one cycle after start_in; busy_out stays 0.
REQ-053 Scenario: second start_in during a len=6 burst -> ignored; exactly 6 words out.
REQ-054 Scenario: rst_in asserted after 3 of 10 words -> all outputs 0 the next cycle; a fresh start with len=2 returns the correct 2 words.

Source files
------------

// File: rtl/bram_reader_pkg.sv
// Shared definitions for the BRAM stream reader.
//   state_e    : reader control states
//   FIFO_DEPTH : skid FIFO entries; must be at least READ_LATENCY+2
//   FIFO_CNT_W : width of a 0..FIFO_DEPTH occupancy count
package bram_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/bram_reader_skid_fifo.sv
// Small synchronous FIFO that absorbs RAM read data behind stream back-pressure.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   push_i, data_i    write request and data
//   pop_i             read request (head is consumed)
//   data_o            current head entry
//   full_o, empty_o   occupancy flags
//   count_o           occupancy 0..FIFO_DEPTH
module bram_reader_skid_fifo #(
  parameter int unsigned RAM_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               push_i,
  input  logic [RAM_WIDTH-1:0]               data_i,
  input  logic                               pop_i,
  output logic [RAM_WIDTH-1:0]               data_o,
  output logic                               full_o,
  output logic                               empty_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [RAM_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic                 do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  // A full FIFO can still accept a write in the same cycle its head leaves.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Reads a burst of consecutive words from a BRAM port and presents them as a
// valid/ready stream, with credit-based flow control into a skid FIFO.
// Optional feature macro: BRAM_READER_LOOP_EN (adds loop_in, repeats the burst).
// Ports:
//   clk_in, rst_in          clock, synchronous active-high reset
//   start_in                burst launch pulse (ignored while busy)
//   base_addr_in, length_in burst start address and word count
//   addr_out, en_out        RAM address / read enable
//   regce_out               RAM output-register enable
//   din_in                  RAM read data
//   data_out, valid_out,    stream data, valid, ready
//   ready_in
//   last_out                final word of a burst
//   busy_out, done_out      burst in progress / completion pulse
//   loop_in                 (BRAM_READER_LOOP_EN only) repeat burst
module bram_stream_reader
  import bram_reader_pkg::*;
#(
  parameter int unsigned RAM_WIDTH    = 16,
  parameter int unsigned RAM_DEPTH    = 4096,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         start_in,
  input  logic [$clog2(RAM_DEPTH)-1:0] base_addr_in,
  input  logic [$clog2(RAM_DEPTH):0]   length_in,
  output logic [$clog2(RAM_DEPTH)-1:0] addr_out,
  output logic                         en_out,
  output logic                         regce_out,
  input  logic [RAM_WIDTH-1:0]         din_in,
  output logic [RAM_WIDTH-1:0]         data_out,
  output logic                         valid_out,
  input  logic                         ready_in,
  output logic                         last_out,
  output logic                         busy_out,
  output logic                         done_out
`ifdef BRAM_READER_LOOP_EN
  ,
  input  logic                         loop_in
`endif
);

  localparam int unsigned ADDR_W = $clog2(RAM_DEPTH);
  localparam int unsigned LEN_W  = ADDR_W + 1;

  state_e                    state_q, state_d;
  logic [ADDR_W-1:0]         addr_q, addr_d, addr_inc;
  logic [ADDR_W-1:0]         base_q, base_d;
  logic [LEN_W-1:0]          len_q, len_d;
  logic [LEN_W-1:0]          issue_cnt_q, issue_cnt_d;
  logic [LEN_W-1:0]          out_cnt_q, out_cnt_d;
  logic [READ_LATENCY-1:0]   tag_q, tag_d;
  logic                      regce_q;
  logic                      done_q, done_d;

  logic                      fifo_full, fifo_empty;
  logic [FIFO_CNT_W-1:0]     fifo_count;
  logic [FIFO_CNT_W-1:0]     inflight;
  logic [FIFO_CNT_W:0]       outstanding;
  logic                      credit_ok, xfer, final_xfer, loop_req;

`ifdef BRAM_READER_LOOP_EN
  assign loop_req = loop_in;
`else
  assign loop_req = 1'b0;
`endif

  bram_reader_skid_fifo #(
    .RAM_WIDTH (RAM_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_in),
    .rst_i  (rst_in),
    .push_i (tag_q[READ_LATENCY-1]),
    .data_i (din_in),
    .pop_i  (xfer),
    .data_o (data_out),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + FIFO_CNT_W'(tag_q[i]);
    end
  end

  // Every issued read owns a FIFO slot from issue until it is transferred out.
  assign outstanding = {1'b0, inflight} + {1'b0, fifo_count};
  assign credit_ok   = !fifo_full && (outstanding < (FIFO_CNT_W+1)'(FIFO_DEPTH));

  assign en_out     = (state_q == ST_ISSUE) && credit_ok;
  assign valid_out  = !fifo_empty;
  assign xfer       = valid_out && ready_in;
  // In DRAIN everything is issued, so the burst ends when the sole remaining word leaves.
  assign final_xfer = xfer && (state_q == ST_DRAIN) && (inflight == '0)
                      && (fifo_count == FIFO_CNT_W'(1));
  assign last_out   = valid_out && (out_cnt_q == LEN_W'(1));
  assign busy_out   = (state_q != ST_IDLE);
  assign done_out   = done_q;
  assign addr_out   = addr_q;
  assign regce_out  = (READ_LATENCY == 1) ? 1'b1 : regce_q;
  assign addr_inc   = (addr_q == ADDR_W'(RAM_DEPTH - 1)) ? '0 : addr_q + 1'b1;
  assign tag_d      = (tag_q << 1) | READ_LATENCY'(en_out);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    base_d      = base_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    out_cnt_d   = out_cnt_q;
    done_d      = 1'b0;

    // Output word position cycles through the burst so last_out stays correct when looping.
    if (xfer) out_cnt_d = (out_cnt_q == LEN_W'(1)) ? len_q : out_cnt_q - 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          if (length_in != '0) begin
            state_d     = ST_ISSUE;
            addr_d      = base_addr_in;
            base_d      = base_addr_in;
            len_d       = length_in;
            issue_cnt_d = length_in;
            out_cnt_d   = length_in;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (en_out) begin
          addr_d      = addr_inc;
          issue_cnt_d = issue_cnt_q - 1'b1;
          if (issue_cnt_q == LEN_W'(1)) begin
            if (loop_req) begin
              addr_d      = base_q;
              issue_cnt_d = len_q;
            end else begin
              state_d = ST_DRAIN;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (final_xfer) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      base_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      tag_q       <= '0;
      regce_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      base_q      <= base_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      out_cnt_q   <= out_cnt_d;
      tag_q       <= tag_d;
      regce_q     <= en_out;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
module tb_bram_stream_reader;

  localparam int W  = 16;
  localparam int D  = 4096;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_in, start_in, ready_in;
  logic [AW-1:0] base_addr_in, addr_out;
  logic [AW:0]   length_in;
  logic          en_out, regce_out, valid_out, last_out, busy_out, done_out;
  logic [W-1:0]  din_in, data_out;

  logic [W-1:0]  mem [D];
  logic [W-1:0]  ram_s1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  bram_stream_reader #(
    .RAM_WIDTH   (W),
    .RAM_DEPTH   (D),
    .READ_LATENCY(2)
  ) dut (
    .clk_in      (clk),
    .rst_in      (rst_in),
    .start_in    (start_in),
    .base_addr_in(base_addr_in),
    .length_in   (length_in),
    .addr_out    (addr_out),
    .en_out      (en_out),
    .regce_out   (regce_out),
    .din_in      (din_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .ready_in    (ready_in),
    .last_out    (last_out),
    .busy_out    (busy_out),
    .done_out    (done_out)
  );

  // Two-stage BRAM: array read on en, output register on regce.
  always @(posedge clk) begin
    if (en_out) ram_s1 <= mem[addr_out];
    if (regce_out) din_in <= ram_s1;
  end

  // Drives one burst and checks the stream against the memory contents.
  // rmode: 0 ready high, 1 ready pattern 1,0,0,1, 2 random ready.
  task automatic run_burst(input int base, input int len, input int rmode,
                           input int restart_cyc, input int stop_after,
                           output int n_xfer, output int n_done,
                           output int first_valid, output int first_en, output int last_en,
                           output int first_xfer, output int last_xfer,
                           output int done_cyc, output int busy_bad);
    int            issued;
    logic          pv, pr, exp_busy, exp_last;
    logic [W-1:0]  pd;
    logic [AW-1:0] exp_addr;
    n_xfer = 0; n_done = 0; first_valid = -1; first_en = -1; last_en = -1;
    first_xfer = -1; last_xfer = -1; done_cyc = -1; busy_bad = 0;
    issued = 0; pv = 1'b0; pr = 1'b0; pd = '0;
    @(negedge clk);
    start_in     = 1'b1;
    base_addr_in = AW'(base);
    length_in    = (AW+1)'(len);
    ready_in     = 1'b1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      start_in = (cyc == restart_cyc);
      if (cyc == restart_cyc) begin
        base_addr_in = AW'(base + 100);
        length_in    = (AW+1)'(3);
      end
      if (en_out) begin
        if (first_en < 0) first_en = cyc;
        last_en  = cyc;
        exp_addr = AW'((base + issued) % D);
        total_cnt++;
        if (addr_out !== exp_addr)
          $display("FAIL addr cyc=%0d got=%0d exp=%0d", cyc, addr_out, exp_addr);
        else pass_cnt++;
        total_cnt++;
        if (issued - n_xfer >= 4)
          $display("FAIL credit cyc=%0d outstanding=%0d exp<4", cyc, issued - n_xfer);
        else pass_cnt++;
        issued++;
      end
      if (valid_out && first_valid < 0) first_valid = cyc;
      if (pv && !pr && valid_out) begin
        total_cnt++;
        if (data_out !== pd)
          $display("FAIL hold cyc=%0d got=%0h exp=%0h", cyc, data_out, pd);
        else pass_cnt++;
      end
      if (done_out) begin n_done++; done_cyc = cyc; end
      exp_busy = (len > 0) && (n_xfer < len);
      if (busy_out !== exp_busy) busy_bad++;
      case (rmode)
        0:       ready_in = 1'b1;
        1:       ready_in = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: ready_in = 1'($urandom_range(0, 1));
      endcase
      if (valid_out) begin
        exp_last = (n_xfer == len - 1);
        total_cnt++;
        if (last_out !== exp_last)
          $display("FAIL last cyc=%0d got=%0b exp=%0b", cyc, last_out, exp_last);
        else pass_cnt++;
      end
      if (valid_out && ready_in) begin
        exp_addr = AW'((base + n_xfer) % D);
        total_cnt++;
        if (data_out !== mem[exp_addr])
          $display("FAIL data word=%0d got=%0h exp=%0h", n_xfer, data_out, mem[exp_addr]);
        else pass_cnt++;
        if (first_xfer < 0) first_xfer = cyc;
        last_xfer = cyc;
        n_xfer++;
      end
      pv = valid_out; pr = ready_in; pd = data_out;
      if (stop_after > 0 && n_xfer == stop_after) return;
      if (n_done > 0 && cyc >= done_cyc + 2) break;
    end
  endtask

  task automatic check_all_zero(input string tag);
    total_cnt++;
    if ({valid_out, en_out, regce_out, busy_out, done_out, last_out} !== 6'b0)
      $display("FAIL %s_flags got=%b exp=000000", tag,
               {valid_out, en_out, regce_out, busy_out, done_out, last_out});
    else pass_cnt++;
    total_cnt++;
    if (addr_out !== '0) $display("FAIL %s_addr got=%0d exp=0", tag, addr_out);
    else pass_cnt++;
    total_cnt++;
    if (data_out !== '0) $display("FAIL %s_data got=%0h exp=0", tag, data_out);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; start_in = 1'b0; ready_in = 1'b1;
    base_addr_in = '0; length_in = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_in = 1'b0;
  endtask

  task automatic test_basic();
    int nx, nd, fv, fe, le, fx, lx, dc, bb;
    run_burst(10, 5, 0, -1, 0, nx, nd, fv, fe, le, fx, lx, dc, bb);
    total_cnt++; if (nx !== 5) $display("FAIL basic_count got=%0d exp=5", nx); else pass_cnt++;
    total_cnt++; if (nd !== 1) $display("FAIL basic_done got=%0d exp=1", nd); else pass_cnt++;
    total_cnt++; if (fv !== 4) $display("FAIL basic_latency got=%0d exp=4", fv); else pass_cnt++;
    total_cnt++;
    if (fe !== 1 || le !== 5) $display("FAIL basic_issue got=%0d..%0d exp=1..5", fe, le);
    else pass_cnt++;
    total_cnt++;
    if (lx - fx !== 4) $display("FAIL basic_throughput got=%0d exp=4", lx - fx); else pass_cnt++;
    total_cnt++;
    if (dc !== lx + 1) $display("FAIL basic_done_cyc got=%0d exp=%0d", dc, lx + 1); else pass_cnt++;
    total_cnt++; if (bb !== 0) $display("FAIL basic_busy got=%0d exp=0", bb); else pass_cnt++;
  endtask

  task automatic test_wrap();
    int nx, nd, fv, fe, le, fx, lx, dc, bb;
    run_burst(4094, 4, 0, -1, 0, nx, nd, fv, fe, le, fx, lx, dc, bb);
    total_cnt++; if (nx !== 4) $display("FAIL wrap_count got=%0d exp=4", nx); else pass_cnt++;
    total_cnt++; if (nd !== 1) $display("FAIL wrap_done got=%0d exp=1", nd); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int nx, nd, fv, fe, le, fx, lx, dc, bb;
    run_burst(int'($urandom_range(0, D - 1)), 8, 1, -1, 0, nx, nd, fv, fe, le, fx, lx, dc, bb);
    total_cnt++; if (nx !== 8) $display("FAIL bp_count got=%0d exp=8", nx); else pass_cnt++;
    total_cnt++; if (nd !== 1) $display("FAIL bp_done got=%0d exp=1", nd); else pass_cnt++;
    total_cnt++; if (bb !== 0) $display("FAIL bp_busy got=%0d exp=0", bb); else pass_cnt++;
  endtask

  task automatic test_zero_len();
    int nx, nd, fv, fe, le, fx, lx, dc, bb;
    run_burst(77, 0, 0, -1, 0, nx, nd, fv, fe, le, fx, lx, dc, bb);
    total_cnt++; if (fv !== -1) $display("FAIL zero_valid got=%0d exp=-1", fv); else pass_cnt++;
    total_cnt++; if (fe !== -1) $display("FAIL zero_en got=%0d exp=-1", fe); else pass_cnt++;
    total_cnt++;
    if (nd !== 1 || dc !== 1) $display("FAIL zero_done got=%0d@%0d exp=1@1", nd, dc);
    else pass_cnt++;
    total_cnt++; if (bb !== 0) $display("FAIL zero_busy got=%0d exp=0", bb); else pass_cnt++;
  endtask

  task automatic test_ignored_start();
    int nx, nd, fv, fe, le, fx, lx, dc, bb;
    run_burst(300, 6, 0, 3, 0, nx, nd, fv, fe, le, fx, lx, dc, bb);
    total_cnt++; if (nx !== 6) $display("FAIL ign_count got=%0d exp=6", nx); else pass_cnt++;
    total_cnt++; if (nd !== 1) $display("FAIL ign_done got=%0d exp=1", nd); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int nx, nd, fv, fe, le, fx, lx, dc, bb;
    run_burst(500, 10, 0, -1, 3, nx, nd, fv, fe, le, fx, lx, dc, bb);
    rst_in   = 1'b1;
    start_in = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    rst_in = 1'b0;
    run_burst(int'($urandom_range(0, D - 1)), 2, 0, -1, 0, nx, nd, fv, fe, le, fx, lx, dc, bb);
    total_cnt++; if (nx !== 2) $display("FAIL post_rst_count got=%0d exp=2", nx); else pass_cnt++;
    total_cnt++; if (nd !== 1) $display("FAIL post_rst_done got=%0d exp=1", nd); else pass_cnt++;
  endtask

  task automatic test_random();
    int nx, nd, fv, fe, le, fx, lx, dc, bb, len;
    for (int k = 0; k < 6; k++) begin
      len = int'($urandom_range(1, 20));
      run_burst(int'($urandom_range(0, D - 1)), len, 2, -1, 0, nx, nd, fv, fe, le, fx, lx, dc, bb);
      total_cnt++;
      if (nx !== len || nd !== 1)
        $display("FAIL rand_burst%0d got=%0d/%0d exp=%0d/1", k, nx, nd, len);
      else pass_cnt++;
    end
  endtask

  initial begin
    for (int i = 0; i < D; i++) mem[i] = W'($urandom);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_ignored_start();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
